// File: rtl/qrd_feed_scheduler_if.sv
// qrd_feed_scheduler_if: vector handshake, skewed array feeds and error capture bus
// master: drives enable, in_valid, in_x1..in_x3, in_d, err_in; observes everything else
// slave : the scheduler; drives in_ready, bc1/ic1/ic2/sk feeds, ready_in_sig,
//         out_valid, out_error, busy, sample_count
interface qrd_feed_scheduler_if #(parameter int DATA_LENGTH = 8);
  logic enable, in_valid, in_ready, ready_in_sig, out_valid, busy;
  logic [DATA_LENGTH-1:0] in_x1, in_x2, in_x3, in_d, err_in;
  logic [DATA_LENGTH-1:0] bc1_out, ic1_out, ic2_out, sk_out, out_error;
  logic [15:0] sample_count;
  modport master (
    output enable, in_valid, in_x1, in_x2, in_x3, in_d, err_in,
    input  in_ready, bc1_out, ic1_out, ic2_out, sk_out, ready_in_sig,
           out_valid, out_error, busy, sample_count
  );
  modport slave (
    input  enable, in_valid, in_x1, in_x2, in_x3, in_d, err_in,
    output in_ready, bc1_out, ic1_out, ic2_out, sk_out, ready_in_sig,
           out_valid, out_error, busy, sample_count
  );
endinterface

// File: rtl/qrd_feed_scheduler.sv
// qrd_feed_scheduler: buffers input vectors and feeds them to a QRD array with 0/1/2 lane skew
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : qrd_feed_scheduler_if.slave (handshake in, skewed feeds out, error capture out)
module qrd_feed_scheduler #(
  parameter int DATA_LENGTH   = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ARRAY_LATENCY = 6
) (
  input logic clk,
  input logic rst_n,
  qrd_feed_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [4*DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic in_ready_q, push, pop, in_flight;
  logic [ARRAY_LATENCY-1:0] flags_q;
  logic [1:0] skew_q;
  logic [DATA_LENGTH-1:0] x1, x2, x3, d;
  logic [DATA_LENGTH-1:0] bc1_q, sk_q, s1_q, ic1_q, t1_q, t2_q, ic2_q, err_q;
  logic rdy_q, ov_q;
  logic [15:0] cnt_q;
  always_comb begin
    push = bus.in_valid && in_ready_q;
    pop = (wptr_q != rptr_q) && bus.enable;
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    {x1, x2, x3, d} = mem_q[rptr_q[AW-1:0]];
    in_flight = |flags_q || |skew_q;
    // IDLE never holds in-flight work, so one rule covers all three states
    state_d = pop ? RUN : (state_q != IDLE && in_flight) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q[AW-1:0]] <= {bus.in_x1, bus.in_x2, bus.in_x3, bus.in_d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      in_ready_q <= 1'b0;
      bc1_q <= '0;
      sk_q <= '0;
      s1_q <= '0;
      ic1_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      ic2_q <= '0;
      err_q <= '0;
      rdy_q <= 1'b0;
      ov_q <= 1'b0;
      skew_q <= '0;
      flags_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      // pointers differing only in the wrap bit means full
      in_ready_q <= (wptr_d ^ rptr_d) != {1'b1, {AW{1'b0}}};
      bc1_q <= pop ? x1 : '0;
      sk_q <= pop ? d : '0;
      rdy_q <= pop;
      s1_q <= pop ? x2 : '0;
      ic1_q <= s1_q;
      t1_q <= pop ? x3 : '0;
      t2_q <= t1_q;
      ic2_q <= t2_q;
      skew_q <= {skew_q[0], pop};
      flags_q <= {flags_q[ARRAY_LATENCY-2:0], pop};
      ov_q <= flags_q[ARRAY_LATENCY-1];
      if (flags_q[ARRAY_LATENCY-1]) err_q <= bus.err_in;
      cnt_q <= cnt_q + {15'd0, pop};
    end
  assign bus.in_ready = in_ready_q;
  assign bus.bc1_out = bc1_q;
  assign bus.ic1_out = ic1_q;
  assign bus.ic2_out = ic2_q;
  assign bus.sk_out = sk_q;
  assign bus.ready_in_sig = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.out_error = err_q;
  assign bus.busy = state_q != IDLE;
  assign bus.sample_count = cnt_q;
endmodule

// File: doc/qrd_feed_scheduler.md
QRD_FEED_SCHEDULER -- requirements
Module: qrd_feed_scheduler

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 8; width of every sample and error bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; input vector buffer depth, a power of 2 and at least 2.
REQ-003 SHALL have parameter ARRAY_LATENCY, default 6; cycles from issue of a vector to its valid error at err_in.
REQ-004 SHALL have ports as follows: clk  in  1  single clock, all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  issue permission; when low, no new vector is issued.
REQ-007 SHALL have ports in_valid  in  1, and in_ready  out  1  (vector handshake).
REQ-008 SHALL have ports in_x1, in_x2, in_x3, in_d  in  DATA_LENGTH each  (one input vector plus desired sample).
REQ-009 SHALL have ports bc1_out, ic1_out, ic2_out, sk_out  out  DATA_LENGTH each  (skewed array feeds).
REQ-010 SHALL have port ready_in_sig  out  1  (update strobe to the array, aligned with bc1_out).
REQ-011 SHALL have port err_in  in  DATA_LENGTH  (array error output).
REQ-012 SHALL have ports out_valid  out  1, and out_error  out  DATA_LENGTH  (captured error).
REQ-013 SHALL have port busy  out  1  (state not IDLE), and sample_count  out  16  (vectors issued).

Function
REQ-014 SHALL accept a vector on any rising edge with in_valid=1 and in_ready=1; in_ready SHALL be the registered FIFO-not-full flag.
REQ-015 SHALL hold a vector offered while in_ready=0 without loss; the offer SHALL be ignored until it is accepted.
REQ-016 SHALL pop at most one vector per cycle, only when the FIFO is non-empty and enable=1; there SHALL be no bypass, so earliest issue is the edge after acceptance.
REQ-017 SHALL, on the pop edge T, register bc1_out=x1, sk_out=d, ready_in_sig=1.
REQ-018 SHALL register ic1_out=x2 at edge T+1 and ic2_out=x3 at edge T+2 (lane skew 0/1/2).
REQ-019 SHALL drive 0 on a lane's bus in a slot with no popped vector, and ready_in_sig SHALL be 0 in that slot; skewed data of earlier pops SHALL still emerge on ic1/ic2.
REQ-020 SHALL track issues in an ARRAY_LATENCY-deep flag shift register; at edge T+ARRAY_LATENCY it SHALL set out_valid=1 and out_error=err_in, otherwise out_valid=0 with out_error held.
REQ-021 SHALL implement states IDLE, RUN and DRAIN: IDLE goes to RUN when the FIFO is non-empty and enable=1.
REQ-022 SHALL transition RUN to DRAIN when no pop is possible while a vector or skew is in flight, and to IDLE when nothing is in flight.
REQ-023 SHALL transition DRAIN to RUN when a pop is possible, and to IDLE when the flag register and skew stages are all empty.
REQ-024 SHALL let an in-flight vector complete its skew and error capture when enable drops.
REQ-025 SHALL increment sample_count on each pop and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 SHALL, on a push and pop in the same cycle, leave the occupancy unchanged; when full, the pop in that cycle SHALL NOT allow a same-edge push.
REQ-027 SHALL use FIFO read/write pointers of log2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all state to IDLE, empty the FIFO and flags, and zero every data output, ready_in_sig, out_valid, busy and sample_count; in_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-029 SHALL, on reset asserted mid-operation, discard in-flight vectors and give no out_valid for them after release.

Verification
REQ-030 SHALL be verified by: single vector (1,2,3,4) accepted at edge 0 with enable=1 -> bc1=1, sk=4, ready_in_sig=1 after edge 1; ic1=2 after edge 2; ic2=3 after edge 3; out_valid pulse after edge 7 with out_error=err_in; then IDLE.
REQ-031 SHALL be verified by: 6 back-to-back vectors with enable=0 -> in_ready drops after 4 accepted; after enable=1, one pop per cycle; all 6 issued in order; sample_count=6.
REQ-032 SHALL be verified by: enable toggled 1,0,1 on alternate cycles with a full FIFO -> zero-filled bubble slots with ready_in_sig=0; skew alignment kept; 3 pops seen in 6 cycles.
REQ-033 SHALL be verified by: rst=0 for one cycle, 2 cycles after an issue -> outputs zero immediately; no out_valid afterwards; busy=0.
REQ-034 SHALL be verified by: sample_count preset by issuing 65535 vectors, then 2 more -> count reads 0xFFFF, 0x0000, 0x0001.
REQ-035 SHALL be verified by: push and pop in the same cycle at occupancy 2 -> occupancy stays 2; data order preserved.
